load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports SHALL be listed in this order, with clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  core presents an access request.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_byte  input  1  1 = byte access, 0 = word access.
- req_signed  input  1  byte load sign-extends when 1, zero-extends when 0.
- req_addr  input  16  byte address.
- req_wdata  input  16  store data; a byte store uses [7:0].
- rsp_valid  output  1  one-cycle response pulse.
- rsp_err  output  1  request rejected; no memory access was made.
- rsp_rdata  output  16  load result; 0 for stores and errors.
- mem_addr  output  16  byte address to data memory.
- mem_wdata  output  16  word write data.
- mem_write  output  1  word write strobe; memory commits it on the clock edge.
- mem_read  output  1  read enable; mem_rdata is valid combinationally in the same cycle.
- mem_rdata  input  16  asynchronous read data.

Function
REQ-002 The FSM SHALL have four states: IDLE, ACCESS, MERGE and RESP.
REQ-003 req_ready SHALL be 1 only in IDLE. A request is accepted when req_valid=1 in IDLE; the unit then latches req_we, req_byte, req_signed, req_addr and req_wdata.
REQ-004 An accepted word access with req_addr[0]=1 SHALL go IDLE->RESP with rsp_err=1 and no memory strobe. rsp_valid is asserted the cycle after acceptance.
REQ-005 In ACCESS, mem_addr SHALL equal the latched address with bit 0 cleared.
- Load: mem_read=1, capture the extracted result, then go to RESP.
- Word store: mem_write=1 with mem_wdata = latched data, then go to RESP.
- Byte store: mem_read=1, capture the full word, then go to MERGE.
REQ-006 In MERGE, mem_write=1 and mem_wdata SHALL be the captured word with the addressed byte replaced by wdata[7:0]. Lane selection: addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8]. Next state is RESP.
REQ-007 A byte load SHALL return the selected lane, sign- or zero-extended per req_signed. A word load SHALL return mem_rdata unchanged.
REQ-008 In RESP, rsp_valid=1 for exactly one cycle; the next state is IDLE. No request is accepted during RESP.
REQ-009 Latency from the acceptance cycle T:
- Misaligned error: rsp_valid at T+1.
- Word load or store, byte load: rsp_valid at T+2.
- Byte store: rsp_valid at T+3.
REQ-010 When no strobe is active, mem_addr and mem_wdata SHALL be 0. mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-011 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.

Reset
REQ-012 While rst=1: state=IDLE, and req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr and mem_wdata SHALL all be 0. req_ready becomes 1 in the first cycle after reset deasserts.
REQ-013 Reset asserted in ACCESS or MERGE SHALL abort the operation. No mem_write is issued for it afterwards and no response is produced; a partially completed byte store leaves memory unmodified.

Configuration
REQ-014 Macro LSU_BYTE_ACCESS_EN:
- Defined: byte loads and stores behave per REQ-005..REQ-007, and the MERGE state exists.
- Undefined: any request with req_byte=1 SHALL take the REQ-004 error path (rsp_err=1 at T+1, no memory access), and MERGE is not implemented.

Structure
REQ-015 The shared package cpu_pkg SHALL hold:
- the FSM state encoding constants;
- the data width (16) and address width (16) constants.
REQ-016 Byte-lane extraction, extension and merge SHALL be a combinational sub-module named lsu_byte_lane.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Word store 0xBEEF to 0x0002, then word load from 0x0002 -> load returns rsp_rdata=0xBEEF at T+2; mem_write seen exactly once, in ACCESS.
- Memory word 0x0004 holds 0x80F0; signed byte load at 0x0005 -> 0xFF80; unsigned byte load at 0x0004 -> 0x00F0.
- Memory word 0x0000 holds 0x1234; byte store 0xAB at 0x0001 -> word becomes 0xAB34; rsp_valid at T+3; mem_read in ACCESS, mem_write in MERGE.
- Word load at 0x0003 -> rsp_err=1 at T+1; mem_read and mem_write stay 0 throughout.
- Byte store to 0x0000 with rst asserted during MERGE -> word at 0x0000 unchanged; no rsp_valid; req_ready=1 in the cycle after rst deasserts.
- Build without LSU_BYTE_ACCESS_EN, byte load at 0x0000 -> rsp_err=1 at T+1 with no memory strobe.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the load/store unit.
// Contents:
//   DATA_W / ADDR_W : data word and byte-address widths (16 bits each)
//   lsu_state_e     : load/store unit FSM state encoding
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane -- combinational byte-lane helper for the load/store unit.
// Ports:
//   i_rdata   : word just read from memory (source for load extraction)
//   i_word    : previously captured word (base for the store merge)
//   i_lane_hi : byte address bit 0; 1 selects bits [15:8], 0 selects [7:0]
//   i_signed  : 1 sign-extends the extracted byte, 0 zero-extends it
//   i_bdata   : byte to insert for a byte store
//   o_load    : extracted and extended byte load result
//   o_merged  : i_word with the addressed lane replaced by i_bdata
module lsu_byte_lane
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_lane_hi,
  input  logic              i_signed,
  input  logic [7:0]        i_bdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_merged
);

  function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        sb;
    logic signed [DATA_W-1:0] sw;
    sb = b;
    sw = sb;
    return sgn ? sw : {{(DATA_W-8){1'b0}}, b};
  endfunction

  logic [7:0] w_lane;

  assign w_lane   = i_lane_hi ? i_rdata[DATA_W-1:8] : i_rdata[7:0];
  assign o_load   = extend_byte(w_lane, i_signed);
  assign o_merged = i_lane_hi ? {i_bdata, i_word[7:0]} : {i_word[DATA_W-1:8], i_bdata};

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding load/store unit between a core and
// a data memory with asynchronous read and clock-edge write commit.
// Build option: define LSU_BYTE_ACCESS_EN to enable byte loads and byte
// stores (read-merge-write through the MERGE state). Without it every
// byte request is rejected with rsp_err like a misaligned word access.
// Ports:
//   clk, rst                : clock and synchronous active-high reset
//   req_valid / req_ready   : request handshake (ready only in IDLE)
//   req_we, req_byte        : store/load and byte/word select
//   req_signed              : sign-extend byte loads
//   req_addr, req_wdata     : byte address and store data
//   rsp_valid               : one-cycle response pulse
//   rsp_err, rsp_rdata      : rejection flag and load result
//   mem_addr, mem_wdata     : word-aligned memory address and write data
//   mem_read, mem_write     : memory strobes (never both at once)
//   mem_rdata               : asynchronous memory read data
module load_store_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;

  logic              r_we;
  logic              r_byte;
  logic              r_signed;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cap;

  logic              w_accept;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_word_addr;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;

`ifdef LSU_BYTE_ACCESS_EN
  assign w_req_err = !req_byte && req_addr[0];
`else
  assign w_req_err = req_byte || req_addr[0];
  // Without byte stores the merge result has no consumer.
  logic w_unused_merge;
  assign w_unused_merge = ^w_merged;
`endif

  assign w_accept    = req_ready && req_valid;
  assign w_word_addr = {r_addr[ADDR_W-1:1], 1'b0};

  lsu_byte_lane u_byte_lane (
    .i_rdata   (mem_rdata),
    .i_word    (r_cap),
    .i_lane_hi (r_addr[0]),
    .i_signed  (r_signed),
    .i_bdata   (r_wdata[7:0]),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch: captured at acceptance, held for the whole operation
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_byte   <= req_byte;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_err    <= w_req_err;
    end
    // Read capture: final load result, or the full word for a byte merge
    if (mem_read) begin
      r_cap <= (!r_we && r_byte) ? w_load : mem_rdata;
    end
  end

  // Outputs are forced low during reset so an in-flight write cannot commit.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            w_next = w_req_err ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          mem_addr = w_word_addr;
          w_next   = RESP;
`ifdef LSU_BYTE_ACCESS_EN
          if (r_we && r_byte) begin
            mem_read = 1'b1;
            w_next   = MERGE;
          end else if (r_we) begin
`else
          if (r_we) begin
`endif
            mem_write = 1'b1;
            mem_wdata = r_wdata;
          end else begin
            mem_read = 1'b1;
          end
        end
`ifdef LSU_BYTE_ACCESS_EN
        MERGE: begin
          mem_addr  = w_word_addr;
          mem_write = 1'b1;
          mem_wdata = w_merged;
          w_next    = RESP;
        end
`endif
        RESP: begin
          rsp_valid = 1'b1;
          rsp_err   = r_err;
          rsp_rdata = (r_err || r_we) ? '0 : r_cap;
          w_next    = IDLE;
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

`ifdef LSU_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_rdata;

  logic        tb_clr = 1'b1;
  logic [15:0] mem     [0:63];
  logic [15:0] ref_mem [0:63];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: asynchronous read, write committed on the clock edge.
  assign mem_rdata = mem[mem_addr[6:1]];
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    end else if (mem_write) begin
      mem[mem_addr[6:1]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Interface invariants checked every cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
    end else begin
      check("rd_wr_exclusive", mem_read && mem_write, 0);
      if (!mem_read && !mem_write) begin
        check("idle_mem_addr", mem_addr, 0);
        check("idle_mem_wdata", mem_wdata, 0);
      end
      if (!rsp_valid) begin
        check("novalid_err", rsp_err, 0);
        check("novalid_rdata", rsp_rdata, 0);
      end
    end
  end

  // Reference model: outcome of one request against ref_mem.
  // Strobe masks have bit k set when the strobe is expected k cycles after acceptance.
  function automatic void model(input logic we, byt, sgn, input logic [15:0] addr, wdata,
                                output logic err, output int lat, output logic [15:0] rdata,
                                output logic [15:0] new_word, output logic [7:0] rdm, wrm);
    int old;
    int b;
    old      = int'(ref_mem[addr[6:1]]);
    b        = (addr % 2 == 1) ? old / 256 : old % 256;
    err      = (byt && !BYTE_EN) || (!byt && addr % 2 == 1);
    rdata    = 16'h0;
    new_word = 16'(old);
    rdm      = 8'h0;
    wrm      = 8'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      rdm = 8'b0000_0010;
      if (!byt) rdata = 16'(old);
      else if (sgn && b >= 128) rdata = 16'(b - 256);
      else rdata = 16'(b);
    end else if (!byt) begin
      lat      = 2;
      wrm      = 8'b0000_0010;
      new_word = wdata;
    end else begin
      lat = 3;
      rdm = 8'b0000_0010;
      wrm = 8'b0000_0100;
      if (addr % 2 == 1) new_word = 16'((int'(wdata) % 256) * 256 + old % 256);
      else new_word = 16'((old / 256) * 256 + int'(wdata) % 256);
    end
  endfunction

  // One request from IDLE to response; called and returning at a negedge.
  task automatic xact(input logic we, byt, sgn, input logic [15:0] addr, wdata,
                      output logic [15:0] got);
    logic        e;
    int          lat;
    int          cyc;
    logic [15:0] exp_rd;
    logic [15:0] nw;
    logic [7:0]  erm, ewm, rm, wm;
    model(we, byt, sgn, addr, wdata, e, lat, exp_rd, nw, erm, ewm);
    check("ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_byte   = byt;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_byte   = 1'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);
    cyc = 1;
    rm  = 8'h0;
    wm  = 8'h0;
    forever begin
      if (mem_read) begin
        rm[cyc] = 1'b1;
        check("rd_addr", mem_addr, {addr[15:1], 1'b0});
      end
      if (mem_write) begin
        wm[cyc] = 1'b1;
        check("wr_addr", mem_addr, {addr[15:1], 1'b0});
        check("wr_data", mem_wdata, nw);
      end
      if (rsp_valid || cyc >= 6) break;
      @(negedge clk);
      cyc++;
    end
    check("rsp_seen", rsp_valid, 1);
    check("latency", cyc, lat);
    check("rsp_err", rsp_err, e);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rd_strobes", rm, erm);
    check("wr_strobes", wm, ewm);
    check("ready_in_resp", req_ready, 0);
    got = rsp_rdata;
    @(negedge clk);
    check("rsp_one_pulse", rsp_valid, 0);
    check("ready_after_resp", req_ready, 1);
    check("mem_commit", mem[addr[6:1]], nw);
    ref_mem[addr[6:1]] = nw;
  endtask

  // Store aborted by reset at the given cycle after acceptance.
  task automatic abort_store(input logic byt, input logic [15:0] addr, wdata, input int at_cyc);
    check("abort_ready", req_ready, 1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (at_cyc - 1) @(negedge clk);
    check("abort_phase_write", mem_write, 1);
    #2 rst = 1'b1;
    #1 check("abort_write_gated", mem_write, 0);
    check("abort_no_rsp", rsp_valid, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after_rst", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_rsp_after", rsp_valid, 0);
      @(negedge clk);
    end
    check("abort_mem_unchanged", mem[addr[6:1]], ref_mem[addr[6:1]]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0;

    repeat (3) @(negedge clk);
    check("reset_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_mem_read", mem_read, 0);
    check("reset_mem_write", mem_write, 0);
    #2;
    rst    = 1'b0;
    tb_clr = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Word store then word load
    xact(1'b1, 1'b0, 1'b0, 16'h0002, 16'hBEEF, got);
    xact(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, got);
    check("word_load_beef", got, 16'hBEEF);

    // Byte loads from word 0x80F0
    xact(1'b1, 1'b0, 1'b0, 16'h0004, 16'h80F0, got);
    xact(1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000, got);
    check("byte_load_signed", got, BYTE_EN ? 16'hFF80 : 16'h0000);
    xact(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, got);
    check("byte_load_unsigned", got, BYTE_EN ? 16'h00F0 : 16'h0000);

    // Byte store into the high lane of 0x1234
    xact(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, got);
    xact(1'b1, 1'b1, 1'b0, 16'h0001, 16'h55AB, got);
    check("byte_store_merge", mem[0], BYTE_EN ? 16'hAB34 : 16'h1234);

    // Misaligned word load
    xact(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, got);

    // Reset during the write phase of a store
    if (BYTE_EN) abort_store(1'b1, 16'h0000, 16'h00CD, 2);
    else         abort_store(1'b0, 16'h0000, 16'h5555, 1);

    // Byte load at 0x0000 (rejected when byte access is disabled)
    xact(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, got);

    // Randomized traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      xact(1'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom_range(0, 127)), 16'($urandom), got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
